// File: rtl/isa_bus_cycle_engine_pkg.sv
// Shared definitions for the ISA bus cycle engine: FSM encoding and control/status bit positions.
package isa_bus_cycle_engine_pkg;

  // Bus cycle phases; 3-bit encoding
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StStrobe = 3'd2,
    StHold   = 3'd3,
    StDone   = 3'd4
  } state_e;

  // control_in bit indices
  localparam int unsigned CTL_WR  = 0;
  localparam int unsigned CTL_RD  = 1;
  localparam int unsigned CTL_W16 = 2;

  // status_out bit indices
  localparam int unsigned STS_BUSY      = 0;
  localparam int unsigned STS_READ      = 1;
  localparam int unsigned STS_TIMEOUT   = 2;
  localparam int unsigned STS_COLLISION = 3;

endpackage

// File: rtl/isa_bus_cycle_engine_sync2.sv
// Two-flop synchroniser for the card's asynchronous IOCHRDY; resets to "ready".
module isa_bus_cycle_engine_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  // Shift the async input through two flops before anyone uses it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/isa_bus_cycle_engine.sv
// Runs one ISA I/O read or write cycle per request edge from the HPS register file.
module isa_bus_cycle_engine
  import isa_bus_cycle_engine_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned STROBE_CYCLES  = 10,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_in,
  input  logic [15:0] data_in,
  input  logic [7:0]  control_in,
  output logic [15:0] data_bus_out,
  output logic        control_reset,
  output logic [7:0]  status_out,
  output logic [15:0] isa_sa,
  output logic [15:0] isa_sd_out,
  output logic        isa_sd_oe,
  input  logic [15:0] isa_sd_in,
  output logic        isa_ior_n,
  output logic        isa_iow_n,
  output logic        isa_aen,
  output logic        isa_sbhe_n,
  input  logic        isa_iochrdy
);

  // Phase counter spans the longest phase, which is the strobe timeout
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ctl_q;
  logic [15:0]      sa_q, sa_d;
  logic [15:0]      sd_out_q, sd_out_d;
  logic [15:0]      dbo_q, dbo_d;
  logic [3:0]       status_q, status_d;
  logic             wide_q, wide_d;
  logic             write_q, write_d;

  logic rdy_sync;
  logic wr_edge, rd_edge;
  logic strobe_min, rdy_exit, to_exit;
  logic active;
  logic unused_ctl;

  assign unused_ctl = ^control_in[7:3];

  isa_bus_cycle_engine_sync2 u_rdy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (isa_iochrdy),
    .q     (rdy_sync)
  );

  assign wr_edge = control_in[CTL_WR] & ~ctl_q[0];
  assign rd_edge = control_in[CTL_RD] & ~ctl_q[1];

  assign strobe_min = (cnt_q >= STROBE_LAST);
  assign rdy_exit   = strobe_min & rdy_sync;
  assign to_exit    = (cnt_q == TIMEOUT_LAST);

  // State, counter and latched cycle parameters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ctl_q    <= 2'b00;
      sa_q     <= 16'h0000;
      sd_out_q <= 16'h0000;
      dbo_q    <= 16'h0000;
      status_q <= 4'h0;
      wide_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctl_q    <= control_in[1:0];
      sa_q     <= sa_d;
      sd_out_q <= sd_out_d;
      dbo_q    <= dbo_d;
      status_q <= status_d;
      wide_q   <= wide_d;
      write_q  <= write_d;
    end
  end

  // Next-state: request detect, phase sequencing, read capture and status updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    sa_d     = sa_q;
    sd_out_d = sd_out_q;
    dbo_d    = dbo_q;
    status_d = status_q;
    wide_d   = wide_q;
    write_d  = write_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (wr_edge && rd_edge) begin
          // Ambiguous request: flag it and just clear the control word
          status_d[STS_COLLISION] = 1'b1;
          state_d                 = StDone;
        end else if (wr_edge || rd_edge) begin
          state_d                 = StSetup;
          sa_d                    = address_in;
          sd_out_d                = data_in;
          wide_d                  = control_in[CTL_W16];
          write_d                 = wr_edge;
          status_d[STS_COLLISION] = 1'b0;
          status_d[STS_TIMEOUT]   = 1'b0;
          status_d[STS_READ]      = rd_edge;
          status_d[STS_BUSY]      = 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end
      end
      StStrobe: begin
        if (rdy_exit || to_exit) begin
          state_d = StHold;
          cnt_d   = '0;
          if (!rdy_exit) begin
            status_d[STS_TIMEOUT] = 1'b1;
          end
          if (!write_q) begin
            dbo_d = wide_q ? isa_sd_in : {8'h00, isa_sd_in[7:0]};
          end
        end
      end
      StHold: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        state_d            = StIdle;
        cnt_d              = '0;
        status_d[STS_BUSY] = 1'b0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus outputs decode straight from the state register so reset releases them at once
  always_comb begin
    active        = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
    isa_aen       = ~active;
    isa_sbhe_n    = ~(active & wide_q);
    isa_sd_oe     = active & write_q;
    isa_iow_n     = ~((state_q == StStrobe) & write_q);
    isa_ior_n     = ~((state_q == StStrobe) & ~write_q);
    control_reset = (state_q != StDone);
    isa_sa        = sa_q;
    isa_sd_out    = sd_out_q;
    data_bus_out  = dbo_q;
    status_out    = {4'h0, status_q};
  end

endmodule

// File: tb/tb_isa_bus_cycle_engine.sv
// Directed bench for isa_bus_cycle_engine: vector table plus hand-written corner sequences.
module tb_isa_bus_cycle_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address_in;
  logic [15:0] data_in;
  logic [7:0]  control_in;
  logic [15:0] data_bus_out;
  logic        control_reset;
  logic [7:0]  status_out;
  logic [15:0] isa_sa;
  logic [15:0] isa_sd_out;
  logic        isa_sd_oe;
  logic [15:0] isa_sd_in;
  logic        isa_ior_n;
  logic        isa_iow_n;
  logic        isa_aen;
  logic        isa_sbhe_n;
  logic        isa_iochrdy;

  always #5 clk = ~clk;

  isa_bus_cycle_engine dut (
    .clk           (clk),
    .reset         (reset),
    .address_in    (address_in),
    .data_in       (data_in),
    .control_in    (control_in),
    .data_bus_out  (data_bus_out),
    .control_reset (control_reset),
    .status_out    (status_out),
    .isa_sa        (isa_sa),
    .isa_sd_out    (isa_sd_out),
    .isa_sd_oe     (isa_sd_oe),
    .isa_sd_in     (isa_sd_in),
    .isa_ior_n     (isa_ior_n),
    .isa_iow_n     (isa_iow_n),
    .isa_aen       (isa_aen),
    .isa_sbhe_n    (isa_sbhe_n),
    .isa_iochrdy   (isa_iochrdy)
  );

  int checks = 0;
  int passes = 0;

  // Observations collected by monitor()
  int m_first_cr, m_cr_cnt, m_iow, m_ior, m_setup;
  int m_oe, m_sbhe, m_sa, m_sdo, m_busy;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  ctl;
    logic [15:0] sd_in;
    int          exp_lat;
    int          exp_iow;
    int          exp_ior;
    int          exp_dbo;
    int          exp_status;
    int          exp_sbhe;
    int          exp_oe;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step a fixed window of clocks, recording bus activity; optionally drop the
  // request when control_reset pulses, as the register file would.
  task automatic monitor(input int window, input bit clear_on_cr);
    m_first_cr = 0; m_cr_cnt = 0; m_iow = 0; m_ior = 0; m_setup = 0;
    m_oe = 0; m_sbhe = -1; m_sa = -1; m_sdo = -1; m_busy = -1;
    for (int n = 1; n <= window; n++) begin
      tick();
      if (!control_reset) begin
        m_cr_cnt++;
        if (m_first_cr == 0) m_first_cr = n;
        if (clear_on_cr) control_in = 8'h00;
      end
      if (!isa_iow_n || !isa_ior_n) begin
        if (!isa_iow_n) m_iow++;
        if (!isa_ior_n) m_ior++;
        m_sa   = int'(isa_sa);
        m_sdo  = int'(isa_sd_out);
        m_sbhe = int'(isa_sbhe_n);
        m_busy = int'(status_out[0]);
      end else if (!isa_aen && m_iow == 0 && m_ior == 0) begin
        m_setup++;
      end
      if (isa_sd_oe) m_oe = 1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " strobes/aen/sbhe/cr/oe"},
          int'({isa_ior_n, isa_iow_n, isa_aen, isa_sbhe_n, control_reset, isa_sd_oe}), 6'b111110);
    check({tag, " sa"}, int'(isa_sa), 0);
    check({tag, " sd_out"}, int'(isa_sd_out), 0);
    check({tag, " data_bus_out"}, int'(data_bus_out), 0);
    check({tag, " status"}, int'(status_out), 0);
  endtask

  initial begin
    int len;
    bit found;

    vecs[0] = '{16'h0220, 16'h00A5, 8'h01, 16'h0000, 15, 10, 0, 16'h0000, 8'h00, 1, 1};
    vecs[1] = '{16'h0388, 16'h1357, 8'h06, 16'hBEEF, 15, 0, 10, 16'hBEEF, 8'h02, 0, 0};
    vecs[2] = '{16'h0300, 16'h1234, 8'h05, 16'h7777, 15, 10, 0, 16'hBEEF, 8'h00, 0, 1};
    vecs[3] = '{16'h0201, 16'h4321, 8'h02, 16'hCAFE, 15, 0, 10, 16'h00FE, 8'h02, 1, 0};

    reset = 1'b0; address_in = '0; data_in = '0; control_in = '0;
    isa_sd_in = '0; isa_iochrdy = 1'b1;
    #12;
    check_reset_vals("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Table of single transactions
    foreach (vecs[i]) begin
      address_in = vecs[i].addr;
      data_in    = vecs[i].data;
      isa_sd_in  = vecs[i].sd_in;
      control_in = vecs[i].ctl;
      monitor(20, 1'b1);
      check($sformatf("v%0d latency", i), m_first_cr, vecs[i].exp_lat);
      check($sformatf("v%0d cr pulses", i), m_cr_cnt, 1);
      check($sformatf("v%0d setup clks", i), m_setup, 2);
      check($sformatf("v%0d iow clks", i), m_iow, vecs[i].exp_iow);
      check($sformatf("v%0d ior clks", i), m_ior, vecs[i].exp_ior);
      check($sformatf("v%0d sa", i), m_sa, int'(vecs[i].addr));
      check($sformatf("v%0d sd_out", i), m_sdo, int'(vecs[i].data));
      check($sformatf("v%0d sbhe_n", i), m_sbhe, vecs[i].exp_sbhe);
      check($sformatf("v%0d busy", i), m_busy, 1);
      check($sformatf("v%0d sd_oe seen", i), m_oe, vecs[i].exp_oe);
      check($sformatf("v%0d data_bus_out", i), int'(data_bus_out), vecs[i].exp_dbo);
      check($sformatf("v%0d status", i), int'(status_out), vecs[i].exp_status);
    end

    // Wait states: IOCHRDY low from strobe clk 3 to strobe clk 20
    address_in = 16'h0388; isa_sd_in = 16'h1111; control_in = 8'h06;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (!isa_ior_n) found = 1'b1;
    end
    check("wait strobe start", int'(found), 1);
    len = 0;
    while (!isa_ior_n && len < 200) begin
      len++;
      if (len == 3) isa_iochrdy = 1'b0;
      if (len == 20) isa_iochrdy = 1'b1;
      if (len == 21) isa_sd_in = 16'h5A3C;
      tick();
    end
    check("wait strobe clks", len, 22);
    monitor(10, 1'b1);
    check("wait cr pulse", m_cr_cnt, 1);
    check("wait data_bus_out", int'(data_bus_out), 16'h5A3C);
    check("wait status", int'(status_out), 8'h02);

    // Timeout: IOCHRDY held low for the whole strobe
    isa_iochrdy = 1'b0;
    tick(); tick(); tick();
    address_in = 16'h02F0; data_in = 16'h0055; control_in = 8'h01;
    monitor(1040, 1'b1);
    check("timeout iow clks", m_iow, 1024);
    check("timeout latency", m_first_cr, 1029);
    check("timeout status", int'(status_out), 8'h04);
    isa_iochrdy = 1'b1;
    tick(); tick(); tick();
    address_in = 16'h0220; data_in = 16'h0011; control_in = 8'h01;
    monitor(20, 1'b1);
    check("post-timeout iow clks", m_iow, 10);
    check("post-timeout status", int'(status_out), 8'h00);

    // Collision: both request edges together
    control_in = 8'h03;
    monitor(10, 1'b1);
    check("collision cr pulses", m_cr_cnt, 1);
    check("collision strobes", m_iow + m_ior, 0);
    check("collision aen", m_setup, 0);
    check("collision status[3]", int'(status_out[3]), 1);
    check("collision busy", int'(status_out[0]), 0);

    // Level held for 50 clocks runs exactly one cycle
    control_in = 8'h01;
    monitor(50, 1'b0);
    check("level cr pulses", m_cr_cnt, 1);
    check("level iow clks", m_iow, 10);
    check("level status", int'(status_out), 8'h00);
    control_in = 8'h00;
    tick();

    // Reset asserted mid-strobe
    address_in = 16'h0220; data_in = 16'h00A5; control_in = 8'h01;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (!isa_iow_n) found = 1'b1;
    end
    check("rst strobe start", int'(found), 1);
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("rst iow_n async", int'(isa_iow_n), 1);
    check_reset_vals("rst mid");
    control_in = 8'h00;
    tick(); tick();
    reset = 1'b1;
    monitor(20, 1'b1);
    check("rst no restart strobes", m_iow + m_ior, 0);
    check("rst no restart cr", m_cr_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
